// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg: shared types and constants for the RV32IC fetch aligner
package riscv_fetch_pkg;
  localparam logic [1:0] RVC_QUAD_32 = 2'b11;
  localparam logic [31:0] DEF_START_PC = 32'h8000006c;
  typedef enum logic [1:0] {BOOT, RUN, HOLD} fetch_state_e;
  typedef logic [15:0] half_t;
endpackage

// File: rtl/fetch_hw_buffer.sv
// fetch_hw_buffer: 4-halfword shift queue, oldest halfword at the bottom
module fetch_hw_buffer
  import riscv_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       app1,
  input  logic       app2,
  input  logic       cons1,
  input  logic       cons2,
  input  half_t      app_lo,
  input  half_t      app_hi,
  output half_t      hw0,
  output half_t      hw1,
  output logic [2:0] count
);
  logic [63:0] q, q_n;
  logic [2:0] base;
  logic [1:0] cons;
  always_comb begin
    cons = cons2 ? 2'd2 : {1'b0, cons1};
    base = count - {1'b0, cons};
    q_n = q >> {cons, 4'b0};
    if (app1 || app2) q_n[{base[1:0], 4'b0} +: 16] = app_lo;
    if (app2) q_n[{base[1:0] + 2'd1, 4'b0} +: 16] = app_hi;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      q <= '0;
      count <= '0;
    end else begin
      q <= clear ? '0 : q_n;
      count <= clear ? 3'd0 : base + {1'b0, app2, app1};
    end
  assign hw0 = q[15:0];
  assign hw1 = q[31:16];
endmodule

// File: rtl/fetch_align_ctrl.sv
// fetch_align_ctrl: word fetch sequencer realigning halfwords into RV32IC instructions
module fetch_align_ctrl
  import riscv_fetch_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              ADDR_W   = 11,
  parameter logic [PC_W-1:0] START_PC = PC_W'(DEF_START_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_compressed
);
  fetch_state_e state;
  logic [PC_W-1:0] fetch_pc;
  logic pending, skip_lo, is32, fire, app;
  logic [2:0] count;
  logic [3:0] occ;
  half_t hw0, hw1;
  logic unused_bit0;
  assign unused_bit0 = redirect_pc[0];
  fetch_hw_buffer u_buf (
    .clk    (clk),
    .reset  (reset),
    .clear  (redirect_valid),
    .app1   (app && skip_lo),
    .app2   (app && !skip_lo),
    .cons1  (fire && !is32),
    .cons2  (fire && is32),
    .app_lo (skip_lo ? mem_rdata[31:16] : mem_rdata[15:0]),
    .app_hi (mem_rdata[31:16]),
    .hw0    (hw0),
    .hw1    (hw1),
    .count  (count)
  );
  // occupancy counts the outstanding word as two halfwords so a response always fits
  assign occ = {1'b0, count} + {2'b0, pending, 1'b0};
  assign mem_req = state == RUN && !redirect_valid && occ <= 4'd2;
  assign mem_addr = fetch_pc[ADDR_W+1:2];
  assign app = pending && !redirect_valid;
  assign is32 = hw0[1:0] == RVC_QUAD_32;
  assign out_valid = count != 3'd0 && (!is32 || count >= 3'd2);
  assign out_compressed = out_valid && !is32;
  assign out_instr = !out_valid ? 32'h0 : is32 ? {hw1, hw0} : {16'h0000, hw0};
  assign fire = out_valid && out_ready && !redirect_valid;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= BOOT;
      pending <= 1'b0;
      skip_lo <= 1'b0;
      fetch_pc <= START_PC;
      out_pc <= START_PC;
    end else begin
      state <= (state == BOOT || fetch_en) ? RUN : HOLD;
      pending <= mem_req;
      skip_lo <= redirect_valid ? redirect_pc[1] : app ? 1'b0 : skip_lo;
      fetch_pc <= redirect_valid ? {redirect_pc[PC_W-1:2], 2'b00} :
                  mem_req ? fetch_pc + PC_W'(4) : fetch_pc;
      out_pc <= redirect_valid ? {redirect_pc[PC_W-1:1], 1'b0} :
                fire ? out_pc + (is32 ? PC_W'(4) : PC_W'(2)) : out_pc;
    end
endmodule

// File: tb/tb_fetch_align_ctrl.sv
// tb_fetch_align_ctrl: random stimulus against an instruction-stream reference model with scoreboard
module tb_fetch_align_ctrl;
  localparam logic [31:0] START = 32'h8000006c;
  logic clk = 0, reset = 1, fetch_en = 0, redirect_valid = 0, out_ready = 0;
  logic [31:0] redirect_pc = 0, mem_rdata = 0;
  logic mem_req, out_valid, out_compressed;
  logic [10:0] mem_addr;
  logic [31:0] out_instr, out_pc;
  fetch_align_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_compressed (out_compressed)
  );
  always #5 clk = ~clk;
  logic [31:0] mem [2048];
  always @(posedge clk) mem_rdata <= mem_req ? mem[mem_addr] : $urandom;
  typedef struct packed {logic [31:0] instr; logic [31:0] pc; logic comp;} exp_t;
  exp_t q[$];
  logic [31:0] mpc, exp_fetch;
  int errors = 0, checks = 0, hs = 0, idle = 0, cyc = 0;
  logic prev_en = 0;
  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] hw_at(input logic [31:0] pc);
    logic [31:0] w;
    w = mem[pc[12:2]];
    return pc[1] ? w[31:16] : w[15:0];
  endfunction
  task automatic top_up();
    exp_t e;
    logic [15:0] h;
    while (q.size() < 8) begin
      h = hw_at(mpc);
      e.pc = mpc;
      e.comp = h[1:0] != 2'b11;
      e.instr = e.comp ? {16'h0000, h} : {hw_at(mpc + 32'd2), h};
      mpc = mpc + (e.comp ? 32'd2 : 32'd4);
      q.push_back(e);
    end
  endtask
  task automatic model_reset(input logic [31:0] pc);
    q.delete();
    mpc = {pc[31:1], 1'b0};
    exp_fetch = {pc[31:2], 2'b00};
    top_up();
  endtask
  task automatic step(input bit rdy, input bit en);
    @(posedge clk);
    #1;
    redirect_valid = 0;
    out_ready = rdy;
    fetch_en = en;
    top_up();
  endtask
  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1;
    redirect_pc = pc;
    model_reset(pc);
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      chk(!out_valid, "rst_out_valid", 32'(out_valid), 0);
      chk(!mem_req, "rst_mem_req", 32'(mem_req), 0);
      chk(out_instr == 0, "rst_out_instr", out_instr, 0);
      chk(!out_compressed, "rst_out_comp", 32'(out_compressed), 0);
      chk(out_pc == START, "rst_out_pc", out_pc, START);
      cyc = 0;
      idle = 0;
    end else begin
      if (redirect_valid) chk(!mem_req, "req_in_redirect", 32'(mem_req), 0);
      else begin
        if (mem_req) begin
          chk(mem_addr == exp_fetch[12:2], "mem_addr", 32'(mem_addr), 32'(exp_fetch[12:2]));
          exp_fetch = exp_fetch + 32'd4;
        end
        if (out_valid) begin
          if (q.size() == 0) chk(0, "scoreboard_empty", out_pc, 0);
          else begin
            chk(out_pc == q[0].pc, "out_pc", out_pc, q[0].pc);
            chk(out_instr == q[0].instr, "out_instr", out_instr, q[0].instr);
            chk(out_compressed == q[0].comp, "out_compressed", 32'(out_compressed), 32'(q[0].comp));
            if (out_ready) begin
              void'(q.pop_front());
              hs++;
              idle = 0;
            end
          end
        end
      end
      if (cyc >= 2 && !prev_en) chk(!mem_req, "req_in_hold", 32'(mem_req), 0);
      if (fetch_en && out_ready) idle++;
      if (idle >= 50) begin
        chk(0, "no_progress", 32'(idle), 50);
        idle = 0;
      end
      prev_en = fetch_en;
      cyc++;
    end
  end
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    mem[11'h01b] = 32'h0000_0013;
    mem[11'h01c] = 32'h0001_4505;
    mem[11'h01d] = 32'h00a0_0093;
    mem[11'h040] = 32'h4197_dead;
    mem[11'h041] = 32'h8082_0001;
    model_reset(START);
    #1 reset = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    fetch_en = 1;
    out_ready = 1;
    repeat (12) step(1, 1);
    for (int i = 0; i < 20 && !mem_req; i++) step(1, 1);
    chk(mem_req, "req_before_redirect", 32'(mem_req), 1);
    step(1, 1);
    do_redirect(32'h80000102);
    repeat (8) step(1, 1);
    repeat (5) step(0, 1);
    repeat (6) step(1, 1);
    for (int i = 0; i < 20 && !mem_req; i++) step(1, 1);
    step(1, 0);
    repeat (6) step(1, 0);
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        @(posedge clk);
        #3 reset = 0;
        redirect_valid = 0;
        model_reset(START);
        repeat (2) @(posedge clk);
        #1 reset = 1;
      end else begin
        step($urandom_range(0, 9) < 7,
             fetch_en ? ($urandom_range(0, 29) != 0) : ($urandom_range(0, 3) == 0));
        if ($urandom_range(0, 39) == 0) do_redirect(32'h8000_0000 | ($urandom & 32'h1fff));
      end
    end
    step(1, 1);
    chk(hs > 300, "handshakes", 32'(hs), 300);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
